// File: rtl/branch_predictor_pkg.sv
// Shared types and sizing for the front-end branch predictor.
package branch_predictor_pkg;

  localparam int unsigned IDX_W      = 6;
  localparam int unsigned TAG_W      = 8;
  localparam int unsigned ENTRIES    = 1 << IDX_W;
  localparam int unsigned BPU_CNT_W  = 2;
  localparam int unsigned BRESULT_WD = 68;

  localparam logic [BPU_CNT_W-1:0] INIT_CNT  = 2'b10;
  localparam logic [BPU_CNT_W-1:0] RESET_CNT = 2'b01;

  // EXE branch-resolution bus, MSB first: {pc, count, is_branch, taken, target}
  typedef struct packed {
    logic [31:0]          pc;
    logic [BPU_CNT_W-1:0] count;
    logic                 is_branch;
    logic                 taken;
    logic [31:0]          target;
  } bresult_t;

  // Saturating 2-bit step, based on the counter value the instruction carried
  function automatic logic [BPU_CNT_W-1:0] sat_step(input logic [BPU_CNT_W-1:0] cnt,
                                                     input logic taken);
    logic [BPU_CNT_W-1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11) res = cnt + 2'b01;
    if (!taken && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, update and prediction signals of the branch predictor.
// Optional BPU_STATS_EN adds the statistics counters.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic                 lk_valid;
  logic [31:0]          lk_pc;
  logic                 lk_stall;
  logic                 flush;
  logic                 upd_valid;
  bresult_t             upd_bresult;
  logic                 upd_bpu_right;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic [BPU_CNT_W-1:0] pred_count;
`ifdef BPU_STATS_EN
  logic [31:0]          stat_branches;
  logic [31:0]          stat_predicted;
  logic [31:0]          stat_mispredict;

  modport master (output lk_valid, lk_pc, lk_stall, flush, upd_valid, upd_bresult, upd_bpu_right,
                  input  pred_valid, pred_taken, pred_target, pred_count,
                         stat_branches, stat_predicted, stat_mispredict);
  modport slave  (input  lk_valid, lk_pc, lk_stall, flush, upd_valid, upd_bresult, upd_bpu_right,
                  output pred_valid, pred_taken, pred_target, pred_count,
                         stat_branches, stat_predicted, stat_mispredict);
`else
  modport master (output lk_valid, lk_pc, lk_stall, flush, upd_valid, upd_bresult, upd_bpu_right,
                  input  pred_valid, pred_taken, pred_target, pred_count);
  modport slave  (input  lk_valid, lk_pc, lk_stall, flush, upd_valid, upd_bresult, upd_bpu_right,
                  output pred_valid, pred_taken, pred_target, pred_count);
`endif
endinterface

// File: rtl/bpu_btb_array.sv
// Flop-based direct-mapped BTB storage: async read with write-first bypass,
// per-field write enables, update-side hit probe, bulk valid clear on reset.
module bpu_btb_array
  import branch_predictor_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid_c,
  output logic [TAG_W-1:0]     rd_tag_c,
  output logic [31:0]          rd_target_c,
  output logic [BPU_CNT_W-1:0] rd_cnt_c,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  output logic                 upd_hit_c,
  input  logic                 we_valid,
  input  logic                 wr_valid,
  input  logic                 we_tag,
  input  logic                 we_target,
  input  logic [31:0]          wr_target,
  input  logic                 we_cnt,
  input  logic [BPU_CNT_W-1:0] wr_cnt
);

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [BPU_CNT_W-1:0] cnt_q    [ENTRIES];
  logic                 same_idx;

  always_ff @(posedge clk) begin
    if (!resetn) valid_q <= '0;
    else if (we_valid) valid_q[wr_idx] <= wr_valid;
  end

  // Payload fields are meaningless while the valid bit is clear, so no reset
  always_ff @(posedge clk) begin
    if (we_tag)    tag_q[wr_idx]    <= wr_tag;
    if (we_target) target_q[wr_idx] <= wr_target;
    if (we_cnt)    cnt_q[wr_idx]    <= wr_cnt;
  end

  always_comb begin
    same_idx    = (rd_idx == wr_idx);
    upd_hit_c   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    rd_valid_c  = (same_idx && we_valid)  ? wr_valid  : valid_q[rd_idx];
    rd_tag_c    = (same_idx && we_tag)    ? wr_tag    : tag_q[rd_idx];
    rd_target_c = (same_idx && we_target) ? wr_target : target_q[rd_idx];
    rd_cnt_c    = (same_idx && we_cnt)    ? wr_cnt    : cnt_q[rd_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// Front-end branch predictor: direct-mapped BTB with 2-bit counters, 1-cycle lookup.
// Define BPU_STATS_EN to add branch/prediction/mispredict statistics counters.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  branch_predictor_if.slave  bus
);

  bresult_t             upd;
  logic [IDX_W-1:0]     lk_idx, u_idx;
  logic [TAG_W-1:0]     lk_tag, u_tag;
  logic                 rd_valid, upd_hit, lk_hit;
  logic [TAG_W-1:0]     rd_tag;
  logic [31:0]          rd_target;
  logic [BPU_CNT_W-1:0] rd_cnt;
  logic                 we_valid, wr_valid, we_tag, we_target, we_cnt;
  logic [BPU_CNT_W-1:0] wr_cnt;
  logic                 unused_bits;

  assign upd    = bus.upd_bresult;
  assign lk_idx = bus.lk_pc[IDX_W+1:2];
  assign lk_tag = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx  = upd.pc[IDX_W+1:2];
  assign u_tag  = upd.pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit = rd_valid && (rd_tag == lk_tag);

`ifdef BPU_STATS_EN
  assign unused_bits = &{1'b0, bus.lk_pc[31:IDX_W+TAG_W+2], bus.lk_pc[1:0],
                         upd.pc[31:IDX_W+TAG_W+2], upd.pc[1:0]};
`else
  assign unused_bits = &{1'b0, bus.lk_pc[31:IDX_W+TAG_W+2], bus.lk_pc[1:0],
                         upd.pc[31:IDX_W+TAG_W+2], upd.pc[1:0], bus.upd_bpu_right};
`endif

  bpu_btb_array u_btb (
    .clk        (clk),
    .resetn     (resetn),
    .rd_idx     (lk_idx),
    .rd_valid_c (rd_valid),
    .rd_tag_c   (rd_tag),
    .rd_target_c(rd_target),
    .rd_cnt_c   (rd_cnt),
    .wr_idx     (u_idx),
    .wr_tag     (u_tag),
    .upd_hit_c  (upd_hit),
    .we_valid   (we_valid),
    .wr_valid   (wr_valid),
    .we_tag     (we_tag),
    .we_target  (we_target),
    .wr_target  (upd.target),
    .we_cnt     (we_cnt),
    .wr_cnt     (wr_cnt)
  );

  // Update policy: train on hit, allocate on taken miss, invalidate non-branch aliases
  always_comb begin
    we_valid  = 1'b0;
    wr_valid  = 1'b0;
    we_tag    = 1'b0;
    we_target = 1'b0;
    we_cnt    = 1'b0;
    wr_cnt    = sat_step(upd.count, upd.taken);
    if (bus.upd_valid) begin
      if (upd.is_branch) begin
        if (upd_hit) begin
          we_cnt    = 1'b1;
          we_target = upd.taken;
        end else if (upd.taken) begin
          we_valid  = 1'b1;
          wr_valid  = 1'b1;
          we_tag    = 1'b1;
          we_target = 1'b1;
          we_cnt    = 1'b1;
          wr_cnt    = INIT_CNT;
        end
      end else if (upd_hit) begin
        we_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
      bus.pred_count  <= RESET_CNT;
    end else if (bus.flush) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
    end else if (!bus.lk_stall) begin
      if (bus.lk_valid && lk_hit) begin
        bus.pred_valid  <= 1'b1;
        bus.pred_taken  <= rd_cnt[1];
        bus.pred_target <= rd_target;
        bus.pred_count  <= rd_cnt;
      end else if (bus.lk_valid) begin
        bus.pred_valid  <= 1'b0;
        bus.pred_taken  <= 1'b0;
        bus.pred_target <= '0;
        bus.pred_count  <= RESET_CNT;
      end else begin
        bus.pred_valid <= 1'b0;
        bus.pred_taken <= 1'b0;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.stat_branches   <= '0;
      bus.stat_predicted  <= '0;
      bus.stat_mispredict <= '0;
    end else if (bus.upd_valid && upd.is_branch) begin
      bus.stat_branches <= bus.stat_branches + 32'd1;
      if (upd_hit)            bus.stat_predicted  <= bus.stat_predicted + 32'd1;
      if (!bus.upd_bpu_right) bus.stat_mispredict <= bus.stat_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// compared every cycle against a table-level reference model.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  branch_predictor_if bif ();

  branch_predictor dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bif)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  bit        m_valid [64];
  bit [7:0]  m_tag   [64];
  bit [31:0] m_tgt   [64];
  bit [1:0]  m_cnt   [64];
  bit        e_valid, e_taken;
  bit [31:0] e_target;
  bit [1:0]  e_count;
  int        e_branches, e_predicted, e_mispredict;

  // stimulus for the next cycle
  logic        s_rst_n, s_lv, s_st, s_fl, s_uv, s_ubr, s_utk, s_right;
  logic [31:0] s_lpc, s_upc, s_utgt;
  logic [1:0]  s_ucnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stim();
    s_rst_n = 1'b1; s_lv = 1'b0; s_lpc = '0; s_st = 1'b0; s_fl = 1'b0;
    s_uv = 1'b0; s_upc = '0; s_ucnt = '0; s_ubr = 1'b0; s_utk = 1'b0;
    s_utgt = '0; s_right = 1'b1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [1:0] cnt, input logic br,
                         input logic tk, input logic [31:0] tgt);
    s_uv = 1'b1; s_upc = pc; s_ucnt = cnt; s_ubr = br; s_utk = tk; s_utgt = tgt;
  endtask

  // Edge behaviour from the rules: update the table first, then answer the lookup
  task automatic model_step();
    int ui, li, c;
    bit [7:0] ut, lt;
    bit uh, lh;
    if (!s_rst_n) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      e_valid = 0; e_taken = 0; e_target = 0; e_count = 2'b01;
      e_branches = 0; e_predicted = 0; e_mispredict = 0;
      return;
    end
    ui = int'((s_upc >> 2) % 32'd64);
    ut = 8'((s_upc >> 8) % 32'd256);
    uh = m_valid[ui] && (m_tag[ui] == ut);
    if (s_uv) begin
      if (s_ubr) begin
        e_branches++;
        if (uh) e_predicted++;
        if (!s_right) e_mispredict++;
        if (uh) begin
          c = int'(s_ucnt) + (s_utk ? 1 : -1);
          if (c < 0) c = 0;
          if (c > 3) c = 3;
          m_cnt[ui] = 2'(c);
          if (s_utk) m_tgt[ui] = s_utgt;
        end else if (s_utk) begin
          m_valid[ui] = 1'b1; m_tag[ui] = ut; m_tgt[ui] = s_utgt; m_cnt[ui] = 2'b10;
        end
      end else if (uh) begin
        m_valid[ui] = 1'b0;
      end
    end
    li = int'((s_lpc >> 2) % 32'd64);
    lt = 8'((s_lpc >> 8) % 32'd256);
    lh = m_valid[li] && (m_tag[li] == lt);
    if (s_fl) begin
      e_valid = 0; e_taken = 0;
    end else if (!s_st) begin
      if (s_lv && lh) begin
        e_valid = 1; e_taken = m_cnt[li][1]; e_target = m_tgt[li]; e_count = m_cnt[li];
      end else if (s_lv) begin
        e_valid = 0; e_taken = 0; e_target = 0; e_count = 2'b01;
      end else begin
        e_valid = 0; e_taken = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    resetn            = s_rst_n;
    bif.lk_valid      = s_lv;
    bif.lk_pc         = s_lpc;
    bif.lk_stall      = s_st;
    bif.flush         = s_fl;
    bif.upd_valid     = s_uv;
    bif.upd_bresult   = {s_upc, s_ucnt, s_ubr, s_utk, s_utgt};
    bif.upd_bpu_right = s_right;
    model_step();
    @(posedge clk);
    #1;
    check("pred_valid",  32'(bif.pred_valid),  32'(e_valid));
    check("pred_taken",  32'(bif.pred_taken),  32'(e_taken));
    check("pred_target", bif.pred_target,      e_target);
    check("pred_count",  32'(bif.pred_count),  32'(e_count));
`ifdef BPU_STATS_EN
    check("stat_branches",   bif.stat_branches,   32'(e_branches));
    check("stat_predicted",  bif.stat_predicted,  32'(e_predicted));
    check("stat_mispredict", bif.stat_mispredict, 32'(e_mispredict));
`endif
  endtask

  logic [31:0] pool [8];
  logic [1:0]  nt_cnts [4];

  initial begin
    pool[0] = 32'hBFC00100; pool[1] = 32'hBFC04100; pool[2] = 32'hBFC00104;
    pool[3] = 32'h00400010; pool[4] = 32'h00410010; pool[5] = 32'hBFC00300;
    pool[6] = 32'h12345678; pool[7] = 32'hBFC08104;
    nt_cnts[0] = 2'b10; nt_cnts[1] = 2'b01; nt_cnts[2] = 2'b00; nt_cnts[3] = 2'b00;

    clear_stim();
    s_rst_n = 1'b0;
    resetn = 1'b0; bif.lk_valid = 0; bif.lk_pc = 0; bif.lk_stall = 0; bif.flush = 0;
    bif.upd_valid = 0; bif.upd_bresult = '0; bif.upd_bpu_right = 1;
    tick(); tick();
    check("rst_valid", 32'(bif.pred_valid), 32'd0);
    check("rst_count", 32'(bif.pred_count), 32'd1);
    check("rst_target", bif.pred_target, 32'd0);

    // cold lookup misses
    clear_stim(); s_lv = 1; s_lpc = 32'hBFC00010; tick();
    check("cold_valid", 32'(bif.pred_valid), 32'd0);
    check("cold_count", 32'(bif.pred_count), 32'd1);

    // allocate on taken miss, then hit
    clear_stim(); set_upd(32'hBFC00100, 2'b01, 1, 1, 32'hBFC00200); tick();
    clear_stim(); s_lv = 1; s_lpc = 32'hBFC00100; tick();
    check("alloc_valid",  32'(bif.pred_valid), 32'd1);
    check("alloc_taken",  32'(bif.pred_taken), 32'd1);
    check("alloc_target", bif.pred_target, 32'hBFC00200);
    check("alloc_count",  32'(bif.pred_count), 32'd2);

    // not-taken training from the bus count, saturating at 0
    for (int i = 0; i < 4; i++) begin
      clear_stim(); set_upd(32'hBFC00100, nt_cnts[i], 1, 0, 32'h0); tick();
    end
    clear_stim(); s_lv = 1; s_lpc = 32'hBFC00100; tick();
    check("nt_valid", 32'(bif.pred_valid), 32'd1);
    check("nt_taken", 32'(bif.pred_taken), 32'd0);
    check("nt_count", 32'(bif.pred_count), 32'd0);

    // same-cycle allocate and lookup
    clear_stim(); set_upd(32'hBFC00300, 2'b11, 1, 1, 32'hBFC00380);
    s_lv = 1; s_lpc = 32'hBFC00300; tick();
    check("byp_valid",  32'(bif.pred_valid), 32'd1);
    check("byp_target", bif.pred_target, 32'hBFC00380);

    // stall holds, flush during stall kills
    clear_stim(); s_lv = 1; s_lpc = 32'hBFC00300; tick();
    for (int i = 0; i < 3; i++) begin
      clear_stim(); s_st = 1; s_lv = 1; s_lpc = pool[i]; tick();
      check("stall_valid",  32'(bif.pred_valid), 32'd1);
      check("stall_target", bif.pred_target, 32'hBFC00380);
    end
    clear_stim(); s_st = 1; s_fl = 1; s_lv = 1; s_lpc = 32'hBFC00300; tick();
    check("flush_valid", 32'(bif.pred_valid), 32'd0);

    // non-branch alias invalidates
    clear_stim(); set_upd(32'h00400010, 2'b01, 1, 1, 32'h00400100); tick();
    clear_stim(); s_lv = 1; s_lpc = 32'h00400010; tick();
    check("alias_pre", 32'(bif.pred_valid), 32'd1);
    clear_stim(); set_upd(32'h00400010, 2'b00, 0, 0, 32'h0); tick();
    clear_stim(); s_lv = 1; s_lpc = 32'h00400010; tick();
    check("alias_post", 32'(bif.pred_valid), 32'd0);

    // three mispredicted branch updates
    for (int i = 0; i < 3; i++) begin
      clear_stim(); set_upd(32'hBFC00100, 2'b01, 1, 1, 32'hBFC00200); s_right = 0; tick();
    end
`ifdef BPU_STATS_EN
    check("mispredict_3", bif.stat_mispredict, 32'd3);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      clear_stim();
      s_rst_n = ($urandom_range(199) != 0);
      s_fl    = ($urandom_range(9) == 0);
      s_st    = ($urandom_range(4) == 0);
      s_lv    = ($urandom_range(3) != 0);
      s_lpc   = pool[$urandom_range(7)];
      s_uv    = ($urandom_range(1) == 0);
      s_upc   = pool[$urandom_range(7)];
      s_ucnt  = 2'($urandom_range(3));
      s_ubr   = ($urandom_range(3) != 0);
      s_utk   = ($urandom_range(1) == 0);
      s_utgt  = $urandom;
      s_right = ($urandom_range(1) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end branch predictor. It is the consumer of the EXE-stage branch-resolution bus `EXE_BResult` (68 bits: {pc[67:36], Count[35:34], is_branch[33], taken[32], target[31:0]}).
- It is also the producer of the prediction fields that travel down the pipe with each instruction: BPU_valid, BPU_is_taken, BPU_ret_addr, Count.
- Structure: direct-mapped BTB with a 2-bit saturating counter per entry.
- Lookup is issued at pre-IF and answered one cycle later. Updates arrive from EXE.

Parameters:
- IDX_W, 6, BTB index width (entries = 2**IDX_W); index = pc[IDX_W+1:2].
- TAG_W, 8, partial tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- INIT_CNT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- lk_valid  in  1  lookup request this cycle.
- lk_pc  in  32  lookup PC.
- lk_stall  in  1  fetch stalled; hold current prediction outputs.
- flush  in  1  exception/branch flush; kills the in-flight lookup response.
- upd_valid  in  1  EXE_BResult qualifier (es_valid && es_to_m1s_valid).
- upd_bresult  in  68  EXE_BResult.
- upd_bpu_right  in  1  es_BPU_right, used for statistics only.
- pred_valid  out  1  BTB hit for the previous lookup (BPU_valid).
- pred_taken  out  1  counter[1] of the hit entry (BPU_is_taken).
- pred_target  out  32  stored target (BPU_ret_addr).
- pred_count  out  2  counter value at prediction (Count).

Behaviour:
- Reset (resetn==0 at a clk edge):
  - All valid bits are cleared in one cycle.
  - Outputs: pred_valid=0, pred_taken=0, pred_target=0, pred_count=2'b01.
  - Tags, targets and counters are don't-care after reset.
- Lookup latency is 1 cycle.
  - If lk_valid && !lk_stall at edge N, outputs update at N+1:
    - hit = valid[idx] && tag[idx]==lk_tag.
    - pred_valid=hit; pred_target=target[idx]; pred_count=cnt[idx]; pred_taken=hit && cnt[idx][1].
  - On a miss: pred_valid=0, pred_taken=0, pred_count=2'b01, pred_target=0.
  - If lk_valid==0 and lk_stall==0: pred_valid=0 next cycle.
  - If lk_stall==1: all outputs hold, regardless of lk_valid.
- Flush priority: flush at edge N forces pred_valid=0 and pred_taken=0 at N+1. Flush has priority over stall and lookup.
- Update: when upd_valid, the entry at index u_idx=pc[IDX_W+1:2] is written at the edge, with u_hit = valid[u_idx] && tag match. Cases:
  - is_branch && u_hit: cnt <= sat(Count + (taken ? +1 : -1)), computed from the bus Count, not the stored counter; saturates at 0 and 3. target <= target when taken, otherwise unchanged.
  - is_branch && !u_hit && taken: allocate. valid=1, tag, target, cnt=INIT_CNT.
  - is_branch && !u_hit && !taken: no write.
  - !is_branch && u_hit (alias / self-modifying): valid <= 0.
  - !is_branch && !u_hit: no write.
- Same-cycle update and lookup to the same index: the lookup observes the post-update entry (write-first bypass), including invalidation.
- Update to a different index never disturbs the lookup.
- Updates are accepted during lk_stall and flush; there is no backpressure on the update path.
- reset (resetn==0) mid-lookup: the response is discarded and outputs take their reset values.

Optional Feature:
- Macro: BPU_STATS_EN.
- With the macro defined, three 32-bit wrap-around counters are added:
  - stat_branches: counts upd_valid && is_branch.
  - stat_predicted: counts upd_valid && is_branch && the entry hit at update.
  - stat_mispredict: counts upd_valid && is_branch && !upd_bpu_right.
  - All three reset to 0 and are exposed as outputs stat_branches, stat_predicted, stat_mispredict.
- Without the macro: no stat ports and no stat logic; the upd_bpu_right port remains, unused.

Decomposition:
- global_defines.vh: BRESULT_WD (68), the bresult field offsets, and BPU_CNT_W (2).
- One sub-module, bpu_btb_array:
  - Flop-based valid/tag/target/counter storage.
  - One async read port, one write port, bulk valid clear.
  - Contains the write-first bypass mux.

Test Plan:
- Reset, then lookup at 0xBFC00010 -> next cycle pred_valid=0, pred_count=2'b01, pred_target=0.
- Update {pc=0xBFC00100, Count=01, is_branch=1, taken=1, target=0xBFC00200}, then lookup 0xBFC00100 -> pred_valid=1, pred_taken=1, pred_target=0xBFC00200, pred_count=2'b10.
- Four not-taken updates to that pc carrying Count=10,01,00,00 -> stored cnt 01,00,00,00; the lookup after them gives pred_taken=0, pred_valid=1.
- Update and lookup of the same pc 0xBFC00300 (allocate taken) in the same cycle -> next cycle pred_valid=1, pred_target=the new target.
- Lookup hits, then lk_stall=1 for 3 cycles with other lk_pc values -> outputs hold; flush during the stall -> pred_valid=0 next cycle.
- Alias: entry at pc 0x00400010; a !is_branch update at the same pc -> subsequent lookup misses. With BPU_STATS_EN, three mispredicted branch updates -> stat_mispredict=3.
